// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and handler-window defaults.
package intr_pkg;

    localparam logic [4:0] ADDR_MASK = 5'b11000;
    localparam logic [4:0] ADDR_PEND = 5'b11001;
    localparam logic [4:0] ADDR_STAT = 5'b11010;
    localparam logic [4:0] ADDR_EOI  = 5'b11011;

    localparam logic [31:0] VEC_LO_DEF = 32'h0000_0180;
    localparam logic [31:0] VEC_HI_DEF = 32'h0000_0200;

    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ASSERT = 2'b01,
        ACTIVE = 2'b10
    } state_t;

    // True when the core PC lies inside the inclusive handler window.
    function automatic logic in_window(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (pc >= lo) && (pc <= hi);
    endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest set bit (index 0 is the highest priority).
module prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        valid = 1'b0;
        index = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            valid = valid | req[i];
            index = req[i] ? i[IDX_W-1:0] : index;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed priority and an
// IDLE/ASSERT/ACTIVE handshake that holds exl until the handler writes EOI.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int                N_SRC    = 4,
    parameter logic [31:0]       VEC_LO   = VEC_LO_DEF,
    parameter logic [31:0]       VEC_HI   = VEC_HI_DEF,
    parameter logic [N_SRC-1:0]  IV_MASK  = {{(N_SRC-1){1'b0}}, 1'b1},
    parameter logic [N_SRC-1:0]  MASK_RST = {N_SRC{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        addr,
    input  logic [31:0]       dataIn,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [31:0]       pc_current,
    output logic [31:0]       rdata,
    output logic              exl,
    output logic              iv,
    output logic [ID_W-1:0]   active_id
);

    state_t              state_r;
    state_t              state_s;
    logic [N_SRC-1:0]    pending_r;
    logic [N_SRC-1:0]    pending_s;
    logic [N_SRC-1:0]    mask_r;
    logic [N_SRC-1:0]    irq_prev_r;
    logic [ID_W-1:0]     active_id_r;
    logic                iv_r;
    logic                exl_r;

    logic                wr_mask_s;
    logic                wr_pend_s;
    logic                wr_eoi_s;
    logic                eoi_clr_s;
    logic [N_SRC-1:0]    set_s;
    logic [N_SRC-1:0]    clr_s;
    logic [N_SRC-1:0]    req_s;
    logic                win_valid_s;
    logic [ID_W-1:0]     win_id_s;
    logic                unused_s;

    assign wr_mask_s = we && (addr == ADDR_MASK);
    assign wr_pend_s = we && (addr == ADDR_PEND);
    assign wr_eoi_s  = we && (addr == ADDR_EOI);

    assign set_s = irq_in & ~irq_prev_r;
    assign req_s = pending_r & mask_r;

    assign unused_s = ^{dataIn[31:N_SRC], 1'b0};

    prio_enc #(
        .N     (N_SRC),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .req   (req_s),
        .valid (win_valid_s),
        .index (win_id_s)
    );

    // Next-state logic; EOI is honoured only once the core is in the handler.
    always_comb begin
        state_s   = state_r;
        eoi_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    state_s = ASSERT;
                end else begin
                    state_s = IDLE;
                end
            end
            ASSERT: begin
                if (in_window(pc_current, VEC_LO, VEC_HI)) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = ASSERT;
                end
            end
            ACTIVE: begin
                if (wr_eoi_s) begin
                    state_s   = IDLE;
                    eoi_clr_s = 1'b1;
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Pending update: new edges are ORed in after clears, so a set beats a clear.
    always_comb begin
        clr_s = {N_SRC{1'b0}};
        if (wr_pend_s) begin
            clr_s = dataIn[N_SRC-1:0];
        end else begin
            clr_s = {N_SRC{1'b0}};
        end
        if (eoi_clr_s) begin
            clr_s = clr_s | ({{(N_SRC-1){1'b0}}, 1'b1} << active_id_r);
        end else begin
            clr_s = clr_s;
        end
        pending_s = (pending_r & ~clr_s) | set_s;
    end

    // Register bank, edge detector, FSM state and registered decoder outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= {N_SRC{1'b0}};
            mask_r      <= MASK_RST;
            irq_prev_r  <= {N_SRC{1'b0}};
            active_id_r <= {ID_W{1'b0}};
            iv_r        <= 1'b0;
            exl_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            pending_r  <= pending_s;
            irq_prev_r <= irq_in;
            exl_r      <= (state_s == ASSERT) || (state_s == ACTIVE);
            if (wr_mask_s) begin
                mask_r <= dataIn[N_SRC-1:0];
            end
            // The winner is frozen here and held untouched until the next IDLE.
            if ((state_r == IDLE) && win_valid_s) begin
                active_id_r <= win_id_s;
                iv_r        <= IV_MASK[win_id_s];
            end
        end
    end

    // Register read mux, combinational from addr.
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            ADDR_MASK: rdata = {{(32-N_SRC){1'b0}}, mask_r};
            ADDR_PEND: rdata = {{(32-N_SRC){1'b0}}, pending_r};
            ADDR_STAT: rdata = {28'h000_0000, state_r, active_id_r};
            default:   rdata = 32'h0000_0000;
        endcase
    end

    assign exl       = exl_r;
    assign iv        = iv_r;
    assign active_id = active_id_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: expectations are queued alongside stimulus
// and drained after the following clock edge (or immediately for settle()).
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam int K_EXL = 0;
    localparam int K_IV  = 1;
    localparam int K_ID  = 2;
    localparam int K_RD  = 3;

    typedef struct {
        int          kind;
        logic [4:0]  a;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] dataIn;
    logic [3:0]  irq_in;
    logic [31:0] pc_current;
    logic [31:0] rdata;
    logic        exl;
    logic        iv;
    logic [1:0]  active_id;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    intr_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .addr       (addr),
        .dataIn     (dataIn),
        .irq_in     (irq_in),
        .pc_current (pc_current),
        .rdata      (rdata),
        .exl        (exl),
        .iv         (iv),
        .active_id  (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [4:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic exp_exl(input logic v, input string tag);
        push(K_EXL, 5'd0, {31'd0, v}, tag);
    endtask

    task automatic exp_rd(input logic [4:0] a, input logic [31:0] v, input string tag);
        push(K_RD, a, v, tag);
    endtask

    task automatic exp_svc(input logic [1:0] id, input logic v_iv, input string tag);
        push(K_EXL, 5'd0, 32'd1, {tag, "_exl"});
        push(K_ID, 5'd0, {30'd0, id}, {tag, "_id"});
        push(K_IV, 5'd0, {31'd0, v_iv}, {tag, "_iv"});
    endtask

    task automatic verify();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_EXL:   obs = {31'd0, exl};
                K_IV:    obs = {31'd0, iv};
                K_ID:    obs = {30'd0, active_id};
                default: begin
                    addr = e.a;
                    #1;
                    obs = rdata;
                end
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic settle();
        #1;
        verify();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        verify();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we     = 1'b1;
        addr   = a;
        dataIn = d;
        @(posedge clk);
        #1;
        we     = 1'b0;
        addr   = 5'd0;
        dataIn = 32'd0;
        verify();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        we         = 1'b0;
        addr       = 5'd0;
        dataIn     = 32'd0;
        irq_in     = 4'b1111;
        pc_current = 32'h0000_0000;

        // Reset with all lines high: nothing may be latched.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        irq_in = 4'b0000;
        exp_exl(1'b0, "rst_exl");
        push(K_IV, 5'd0, 32'd0, "rst_iv");
        push(K_ID, 5'd0, 32'd0, "rst_id");
        exp_rd(ADDR_MASK, 32'd0, "rst_mask");
        exp_rd(ADDR_PEND, 32'd0, "rst_pend");
        settle();
        exp_rd(ADDR_STAT, 32'd0, "rst_stat");
        exp_rd(ADDR_PEND, 32'd0, "rst_pend_after");
        exp_rd(5'b00101, 32'd0, "unmapped_rd");
        cyc();

        // Basic service of source 1.
        exp_rd(ADDR_MASK, 32'h3, "mask_wr");
        wr(ADDR_MASK, 32'h3);
        irq_in = 4'b0010;
        exp_rd(ADDR_PEND, 32'h2, "basic_pend");
        exp_exl(1'b0, "basic_exl_t1");
        cyc();
        irq_in = 4'b0000;
        exp_svc(2'd1, 1'b0, "basic");
        cyc();
        pc_current = 32'h0000_0180;
        exp_rd(ADDR_STAT, 32'h9, "basic_stat");
        exp_exl(1'b1, "basic_active_exl");
        cyc();
        exp_exl(1'b0, "basic_eoi_exl");
        exp_rd(ADDR_PEND, 32'h0, "basic_eoi_pend");
        exp_rd(ADDR_STAT, 32'h1, "basic_eoi_stat");
        wr(ADDR_EOI, 32'h0);
        pc_current = 32'h0000_0000;

        // Priority and no nesting: 0 wins, 2 follows after a 1-cycle gap.
        wr(ADDR_MASK, 32'h5);
        irq_in = 4'b0101;
        exp_rd(ADDR_PEND, 32'h5, "prio_pend");
        cyc();
        irq_in = 4'b0000;
        exp_svc(2'd0, 1'b1, "prio_first");
        cyc();
        pc_current = 32'h0000_0200;
        exp_rd(ADDR_STAT, 32'h8, "prio_stat_hi_edge");
        cyc();
        exp_exl(1'b0, "prio_gap");
        exp_rd(ADDR_PEND, 32'h4, "prio_pend_left");
        wr(ADDR_EOI, 32'h0);
        pc_current = 32'h0000_017F;
        exp_svc(2'd2, 1'b0, "prio_second");
        cyc();
        exp_rd(ADDR_STAT, 32'h6, "prio_below_window");
        cyc();
        pc_current = 32'h0000_0180;
        exp_rd(ADDR_STAT, 32'hA, "prio_lo_edge");
        cyc();
        exp_exl(1'b0, "prio_eoi2");
        exp_rd(ADDR_PEND, 32'h0, "prio_pend_clr");
        wr(ADDR_EOI, 32'h0);
        pc_current = 32'h0000_0000;

        // Masking.
        wr(ADDR_MASK, 32'h0);
        irq_in = 4'b1000;
        exp_rd(ADDR_PEND, 32'h8, "mask_pend");
        cyc();
        irq_in = 4'b0000;
        exp_exl(1'b0, "mask_blocked");
        cyc();
        exp_exl(1'b0, "unmask_edge");
        wr(ADDR_MASK, 32'h8);
        exp_svc(2'd3, 1'b0, "unmask");
        cyc();
        pc_current = 32'h0000_0190;
        cyc();
        exp_rd(ADDR_PEND, 32'h0, "unmask_eoi_pend");
        wr(ADDR_EOI, 32'h0);
        pc_current = 32'h0000_0000;
        wr(ADDR_MASK, 32'h0);
        irq_in = 4'b1000;
        cyc();
        irq_in = 4'b0000;
        exp_rd(ADDR_PEND, 32'h0, "w1c_pend");
        wr(ADDR_PEND, 32'h8);
        wr(ADDR_MASK, 32'h8);
        exp_exl(1'b0, "w1c_no_req");
        cyc();

        // Collisions: set beats W1C, and a re-edge at EOI is re-serviced.
        wr(ADDR_MASK, 32'h0);
        irq_in = 4'b0010;
        cyc();
        irq_in = 4'b0000;
        cyc();
        irq_in = 4'b0010;
        exp_rd(ADDR_PEND, 32'h2, "coll_set_wins");
        wr(ADDR_PEND, 32'h2);
        irq_in = 4'b0000;
        exp_rd(ADDR_PEND, 32'h0, "coll_w1c");
        wr(ADDR_PEND, 32'h2);
        wr(ADDR_MASK, 32'h2);
        irq_in = 4'b0010;
        cyc();
        irq_in = 4'b0000;
        exp_svc(2'd1, 1'b0, "coll_svc");
        cyc();
        pc_current = 32'h0000_0180;
        cyc();
        irq_in = 4'b0010;
        exp_exl(1'b0, "coll_eoi_exl");
        exp_rd(ADDR_PEND, 32'h2, "coll_eoi_pend");
        wr(ADDR_EOI, 32'h0);
        irq_in     = 4'b0000;
        pc_current = 32'h0000_0040;
        exp_svc(2'd1, 1'b0, "coll_reservice");
        exp_rd(ADDR_STAT, 32'h5, "guard_stat");
        cyc();

        // Guard: EOI outside the handler is ignored; then reset from ACTIVE.
        exp_exl(1'b1, "guard_eoi_exl");
        exp_rd(ADDR_STAT, 32'h5, "guard_eoi_stat");
        exp_rd(ADDR_PEND, 32'h2, "guard_eoi_pend");
        wr(ADDR_EOI, 32'h0);
        pc_current = 32'h0000_0201;
        exp_rd(ADDR_STAT, 32'h5, "guard_above_window");
        cyc();
        pc_current = 32'h0000_01A0;
        exp_rd(ADDR_STAT, 32'h9, "guard_active");
        cyc();
        rst = 1'b1;
        exp_exl(1'b0, "rst_mid_exl");
        exp_rd(ADDR_STAT, 32'h0, "rst_mid_stat");
        exp_rd(ADDR_PEND, 32'h0, "rst_mid_pend");
        exp_rd(ADDR_MASK, 32'h0, "rst_mid_mask");
        cyc();
        rst = 1'b0;
        exp_exl(1'b0, "rst_mid_after");
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller for the single-cycle MIPS core. Collects peripheral interrupt lines, latches them as pending, and applies a mask and a fixed priority.
- Drives the `EXL`/`IV` inputs of the main decoder so the core vectors into the handler window. Holds the request until the handler signals end-of-interrupt (EOI).
- Register-programmed over the same `we`/`addr[4:0]`/`dataIn` bus the timer uses. Sits between the timer, debounced buttons and the core control path.

Parameters:
- N_SRC, 4, number of interrupt sources; index 0 has the highest priority.
- VEC_LO, 32'h180, lowest handler PC (inclusive).
- VEC_HI, 32'h200, highest handler PC (inclusive).
- IV_MASK, 4'b0001 (N_SRC bits), per-source value driven on `iv` while that source is serviced.
- MASK_RST, 4'b0000 (N_SRC bits), reset value of the mask register.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- we  in  1  register write enable
- addr  in  5  register address
- dataIn  in  32  register write data
- irq_in  in  N_SRC  level interrupt lines from peripherals (timer flag, debounced buttons)
- pc_current  in  32  current core PC
- rdata  out  32  register read data, combinational from `addr`
- exl  out  1  exception level request to the main decoder
- iv  out  1  vector select to the main decoder
- active_id  out  2  index of the source being serviced

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - `exl` = 0, `iv` = 0, `active_id` = 0.
  - State = IDLE; pending = 0; mask = MASK_RST; irq_prev = 0.
- Register map:
  - 5'b11000 MASK, R/W, bits[N_SRC-1:0].
  - 5'b11001 PEND: read returns pending; a write clears every bit where `dataIn` = 1 (write-1-to-clear).
  - 5'b11010 STAT, read-only: {state[1:0], active_id[1:0]} in bits[3:0].
  - 5'b11011 EOI: a write of any value signals end-of-interrupt.
  - Any other address: `rdata` = 0 and writes are ignored.
- Edge detect: irq_prev <= irq_in every cycle. pending[i] sets on a clock where irq_in[i] = 1 and irq_prev[i] = 0.
- Set/clear collision: if a set and a PEND clear hit the same bit in the same cycle, set wins.
- Priority: among (pending & mask), the lowest index wins.
- State IDLE:
  - `exl` = 0.
  - If (pending & mask) != 0: latch the winner into `active_id`, register `iv` = IV_MASK[winner], and move to ASSERT.
- State ASSERT:
  - `exl` = 1.
  - When VEC_LO <= pc_current <= VEC_HI, move to ACTIVE.
  - EOI writes are ignored in this state.
- State ACTIVE:
  - `exl` = 1.
  - On an EOI write: clear pending[active_id], drive `exl` = 0 from the next cycle, and return to IDLE.
  - If that source re-edges in the same cycle as EOI, set wins and the bit stays pending.
- Timing:
  - From an irq_in rising edge, pending sets at the next clock and `exl` is high one clock after that: 2 clocks total.
  - After EOI, IDLE can re-arbitrate on the following clock, so the minimum `exl` low gap is 1 cycle.
- Mid-service changes:
  - Clearing a mask bit or PEND bit during ASSERT/ACTIVE does not abort service. `active_id` and `iv` stay frozen until EOI.
  - A higher-priority source arriving during service stays pending; there is no nesting.
- Reset mid-operation: a `rst` in any state forces all reset values at the next clock.
- Unused state encoding 2'b11 returns to IDLE with `exl` = 0.

Decomposition:
- Shared package `intr_pkg`:
  - Register address constants ADDR_MASK, ADDR_PEND, ADDR_STAT, ADDR_EOI.
  - State encodings IDLE = 2'b00, ASSERT = 2'b01, ACTIVE = 2'b10.
  - VEC_LO/VEC_HI defaults.
- One sub-module `prio_enc` (N_SRC-bit request in; outputs `valid` and `index` of the lowest set bit), combinational.

Test Plan:
- Reset then idle: `rst` = 1 for 2 cycles with irq_in = 4'b1111 → `exl` = 0, `rdata`@MASK = 0, PEND reads 0 after reset (edges during reset ignored).
- Basic service: write MASK = 4'b0011; raise irq_in[1] at cycle t → PEND = 4'b0010 at t+1; `exl` = 1, `active_id` = 1, `iv` = 0 at t+2; pc_current = 32'h180 → STAT = 4'b1001; EOI write → `exl` = 0 next cycle, PEND = 0.
- Priority and no-nesting: irq_in[2] and irq_in[0] rise together with MASK = 4'b0101 → `active_id` = 0, `iv` = 1. After EOI, source 2 serviced next with `exl` low for exactly 1 cycle.
- Masking: MASK = 0, irq_in[3] rises → PEND = 4'b1000, `exl` stays 0. Writing MASK = 4'b1000 → `exl` = 1 within 1 cycle. A PEND write of 4'b1000 before unmasking → no request.
- Collision: in the same cycle, a PEND write of 4'b0010 and an irq_in[1] rising edge → PEND bit 1 remains 1. EOI coinciding with a re-edge of the active source → the source is re-serviced.
- Guard and reset: EOI during ASSERT (pc_current = 32'h40) → ignored, `exl` stays 1. `rst` asserted in ACTIVE → `exl` = 0, state IDLE, pending = 0 next clock.
